// File: rtl/dequeue_sequencer.sv
//------------------------------------------------------------------------------
// dequeue_sequencer: holds an accepted ICD mask as a pending set and issues one
// dequeue pulse per requested channel once that channel is non-empty.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dequeue_sequencer #(
  parameter int NUM_CHANNELS      = 4,
  parameter int STALL_COUNT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES    = 200
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         flush,
  input  logic                         request_valid,
  input  logic [NUM_CHANNELS-1:0]      request_icd,
  output logic                         request_ready,
  input  logic [NUM_CHANNELS-1:0]      channel_empty,
  output logic [NUM_CHANNELS-1:0]      dequeue_signals,
  output logic [NUM_CHANNELS-1:0]      pending,
  output logic                         busy,
  output logic [STALL_COUNT_WIDTH-1:0] stall_count,
  output logic                         timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [STALL_COUNT_WIDTH-1:0] STALL_MAX    = '1;
  localparam logic [STALL_COUNT_WIDTH-1:0] TIMEOUT_LAST = STALL_COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic [NUM_CHANNELS-1:0] fire;
  logic [NUM_CHANNELS-1:0] remaining;
  logic [NUM_CHANNELS-1:0] next_pending;
  logic                    accept;
  logic                    stalled;

  // Reset gates fire so a reset arriving mid-drain never emits a pulse.
  always_comb begin
    fire          = (enable && !flush && !reset) ? (pending & ~channel_empty) : '0;
    remaining     = pending & ~fire;
    request_ready = reset ? enable : (enable && !flush && (remaining == '0));
    accept        = request_valid && request_ready && !reset;
    next_pending  = accept ? request_icd : remaining;
    stalled       = (state == DRAIN) && (fire == '0);
  end

  assign dequeue_signals = fire;
  assign busy            = (state == DRAIN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      stall_count <= '0;
      timeout     <= 1'b0;
    end else if (enable) begin
      if (flush) begin
        state       <= IDLE;
        pending     <= '0;
        stall_count <= '0;
      end else begin
        pending <= next_pending;
        state   <= (next_pending != '0) ? DRAIN : IDLE;
        if (stalled) begin
          if (stall_count != STALL_MAX) begin
            stall_count <= stall_count + 1'b1;
          end
          if (stall_count == TIMEOUT_LAST) begin
            timeout <= 1'b1;
          end
        end else begin
          stall_count <= '0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dequeue_sequencer.sv
//------------------------------------------------------------------------------
// tb_dequeue_sequencer: directed and random stimulus against a pending-set model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dequeue_sequencer;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 5;
  localparam int SAT = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic         flush = 1'b0;
  logic         request_valid = 1'b0;
  logic [N-1:0] request_icd = '0;
  logic         request_ready;
  logic [N-1:0] channel_empty = '0;
  logic [N-1:0] dequeue_signals;
  logic [N-1:0] pending;
  logic         busy;
  logic [W-1:0] stall_count;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: a set of outstanding channels plus a stall counter.
  bit m_pend [N];
  int m_stall = 0;
  bit m_tout = 1'b0;

  dequeue_sequencer #(
    .NUM_CHANNELS(N),
    .STALL_COUNT_WIDTH(W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .flush(flush),
    .request_valid(request_valid),
    .request_icd(request_icd),
    .request_ready(request_ready),
    .channel_empty(channel_empty),
    .dequeue_signals(dequeue_signals),
    .pending(pending),
    .busy(busy),
    .stall_count(stall_count),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic check_bits(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle, checks at the falling edge, then advances the model.
  task automatic step(input logic r, input logic e, input logic f, input logic v,
                      input logic [N-1:0] icd, input logic [N-1:0] emp,
                      input string tag, output bit acc);
    logic [N-1:0] exp_fire, exp_pend;
    bit           exp_ready, any_pend, any_left;
    reset = r; enable = e; flush = f; request_valid = v;
    request_icd = icd; channel_empty = emp;
    #4;
    exp_fire = '0; exp_pend = '0; any_pend = 0; any_left = 0;
    for (int i = 0; i < N; i++) begin
      exp_pend[i] = m_pend[i];
      if (m_pend[i]) any_pend = 1;
      if (!r && e && !f && m_pend[i] && !emp[i]) exp_fire[i] = 1'b1;
      else if (m_pend[i]) any_left = 1;
    end
    exp_ready = r ? e : (e && !f && !any_left);
    acc = !r && v && exp_ready;
    check_bits({tag, ".deq"},     W'(dequeue_signals), W'(exp_fire));
    check_bits({tag, ".ready"},   W'(request_ready),   W'(exp_ready));
    check_bits({tag, ".pending"}, W'(pending),         W'(exp_pend));
    check_bits({tag, ".busy"},    W'(busy),            W'(any_pend));
    check_bits({tag, ".stall"},   stall_count,         W'(m_stall));
    check_bits({tag, ".timeout"}, W'(timeout),         W'(m_tout));
    if (r) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_stall = 0; m_tout = 0;
    end else if (e && f) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_stall = 0;
    end else if (e) begin
      if (any_pend && exp_fire == '0) begin
        if (m_stall < SAT) m_stall++;
        if (m_stall == TMO) m_tout = 1;
      end else begin
        m_stall = 0;
      end
      for (int i = 0; i < N; i++)
        m_pend[i] = acc ? icd[i] : (m_pend[i] && !exp_fire[i]);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit           acc;
    bit           rq_v;
    logic [N-1:0] rq_icd;
    logic         r, e, f;
    logic [N-1:0] emp;
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    @(posedge clock);
    #1;
    step(1, 1, 0, 0, '0, '0, "reset0", acc);
    step(1, 1, 0, 1, 4'b1111, '0, "reset1", acc);

    // basic drain
    step(0, 1, 0, 1, 4'b0101, 4'b0000, "basic_acc", acc);
    step(0, 1, 0, 0, '0, 4'b0000, "basic_fire", acc);
    step(0, 1, 0, 0, '0, 4'b0000, "basic_idle", acc);

    // partial availability
    step(0, 1, 0, 1, 4'b1111, 4'b1010, "part_acc", acc);
    step(0, 1, 0, 0, '0, 4'b1010, "part_lo", acc);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, '0, 4'b1010, "part_stall", acc);
    step(0, 1, 0, 0, '0, 4'b0000, "part_hi", acc);
    step(0, 1, 0, 0, '0, 4'b0000, "part_idle", acc);

    // back-to-back, no idle bubble
    step(0, 1, 0, 1, 4'b0011, 4'b0000, "b2b_acc", acc);
    step(0, 1, 0, 1, 4'b1000, 4'b0000, "b2b_fire_acc", acc);
    step(0, 1, 0, 0, '0, 4'b0000, "b2b_second", acc);

    // zero mask
    step(0, 1, 0, 1, 4'b0000, 4'b0000, "zero_acc", acc);
    step(0, 1, 0, 0, '0, 4'b0000, "zero_idle", acc);

    // timeout, flush keeps timeout, saturation, reset clears
    step(0, 1, 0, 1, 4'b0001, 4'b0001, "tmo_acc", acc);
    for (int k = 0; k < 8; k++) step(0, 1, 0, 0, '0, 4'b0001, "tmo_stall", acc);
    step(0, 1, 1, 0, '0, 4'b0001, "tmo_flush", acc);
    step(0, 1, 0, 0, '0, 4'b0001, "tmo_after_flush", acc);
    step(0, 1, 0, 1, 4'b0001, 4'b0001, "sat_acc", acc);
    for (int k = 0; k < 260; k++) step(0, 1, 0, 0, '0, 4'b0001, "sat_stall", acc);
    step(1, 1, 0, 0, '0, 4'b0001, "tmo_reset", acc);
    step(0, 1, 0, 0, '0, 4'b0000, "tmo_cleared", acc);

    // enable low freezes state
    step(0, 1, 0, 1, 4'b0110, 4'b1111, "en_acc", acc);
    step(0, 1, 0, 0, '0, 4'b1111, "en_stall", acc);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, '0, 4'b0000, "en_low", acc);
    step(0, 1, 0, 0, '0, 4'b0000, "en_fire", acc);
    step(0, 1, 0, 1, 4'b0110, 4'b1111, "fl_acc", acc);
    step(0, 1, 1, 1, 4'b0011, 4'b0000, "fl_flush", acc);
    step(0, 1, 0, 0, '0, 4'b0000, "fl_idle", acc);

    // reset mid-drain
    step(0, 1, 0, 1, 4'b1001, 4'b1111, "rmid_acc", acc);
    step(1, 1, 0, 0, '0, 4'b0000, "rmid_reset", acc);
    step(0, 1, 0, 0, '0, 4'b0000, "rmid_after", acc);

    // random traffic; requester holds its mask until accepted
    rq_v = 0;
    rq_icd = '0;
    for (int k = 0; k < 1500; k++) begin
      if (!rq_v && $urandom_range(0, 2) == 0) begin
        rq_v = 1;
        rq_icd = N'($urandom);
      end
      r   = ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 9) != 0);
      f   = ($urandom_range(0, 39) == 0);
      emp = ($urandom_range(0, 19) == 0) ? 4'b1111 : N'($urandom & $urandom);
      step(r, e, f, rq_v, rq_icd, emp, "rnd", acc);
      if (acc) rq_v = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
